// File: rtl/clock_time_ctrl.sv
// Timekeeping controller: 1 Hz prescaler, BCD HH:MM:SS counters and a
// RUN / SET_H / SET_M mode machine driven by two debounced buttons.
module clock_time_ctrl #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [1:0] mode,
  output logic       blink,
  output logic       sec_tick
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PCNT_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PCNT_HALF = PW'(TICK_DIV / 2 - 1);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_SET_H = 2'd1,
    S_SET_M = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pcnt, pcnt_nxt;
  logic          phase, phase_nxt;
  logic          mode_q, inc_q;
  logic          tick, mode_edge, inc_edge, leave_set;
  logic [7:0]    hour_nxt, min_nxt, sec_nxt;

  // Wrapping BCD increment; maxv is the last legal value of the field.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] maxv);
    if (v == maxv)          return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign tick      = (pcnt == PCNT_LAST);
  assign mode_edge = mode_btn & ~mode_q;
  assign inc_edge  = inc_btn & ~inc_q;
  assign leave_set = mode_edge && (state == S_SET_M);
  assign mode      = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (mode_edge) begin
      unique case (state)
        S_RUN:   state_nxt = S_SET_H;
        S_SET_H: state_nxt = S_SET_M;
        default: state_nxt = S_RUN;
      endcase
    end
  end

  // Prescaler and blink phase; leaving SET_M restarts the second cleanly.
  always_comb begin
    pcnt_nxt  = tick ? '0 : pcnt + PW'(1);
    phase_nxt = phase ^ (tick || (pcnt == PCNT_HALF));
    if (leave_set) begin
      pcnt_nxt  = '0;
      phase_nxt = 1'b0;
    end
  end

  // All time fields resolve in one place so they commit on the same edge.
  always_comb begin
    hour_nxt = hour_bcd;
    min_nxt  = min_bcd;
    sec_nxt  = sec_bcd;
    unique case (state)
      S_RUN: begin
        if (tick) begin
          sec_nxt = bcd_inc(sec_bcd, 8'h59);
          if (sec_bcd == 8'h59) begin
            min_nxt = bcd_inc(min_bcd, 8'h59);
            if (min_bcd == 8'h59) hour_nxt = bcd_inc(hour_bcd, 8'h23);
          end
        end
      end
      S_SET_H: begin
        if (inc_edge && !mode_edge) hour_nxt = bcd_inc(hour_bcd, 8'h23);
      end
      default: begin
        if (inc_edge && !mode_edge) min_nxt = bcd_inc(min_bcd, 8'h59);
        if (mode_edge)              sec_nxt = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt     <= '0;
      phase    <= 1'b0;
      mode_q   <= 1'b0;
      inc_q    <= 1'b0;
      hour_bcd <= 8'h00;
      min_bcd  <= 8'h00;
      sec_bcd  <= 8'h00;
      blink    <= 1'b0;
      sec_tick <= 1'b0;
    end else begin
      pcnt     <= pcnt_nxt;
      phase    <= phase_nxt;
      mode_q   <= mode_btn;
      inc_q    <= inc_btn;
      hour_bcd <= hour_nxt;
      min_bcd  <= min_nxt;
      sec_bcd  <= sec_nxt;
      blink    <= phase_nxt && (state_nxt != S_RUN);
      sec_tick <= tick && (state == S_RUN);
    end
  end

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Bench for clock_time_ctrl: directed scenarios plus random button traffic,
// checked every cycle against a seconds-of-day reference model.
module tb_clock_time_ctrl;

  localparam int unsigned D = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic [7:0] hour_bcd, min_bcd, sec_bcd;
  logic [1:0] mode;
  logic       blink, sec_tick;

  clock_time_ctrl #(.TICK_DIV(D)) dut (
    .clk(clk), .rst(rst), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .hour_bcd(hour_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
    .mode(mode), .blink(blink), .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: time as seconds of day, mode as 0/1/2, prescaler position.
  int t, md, p;
  bit ph, ex_tick, mbq, ibq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic logic [23:0] hms(input int h, input int m, input int s);
    return {to_bcd(h), to_bcd(m), to_bcd(s)};
  endfunction

  task automatic m_reset();
    t = 0; md = 0; p = 0; ph = 0; ex_tick = 0; mbq = 0; ibq = 0;
  endtask

  task automatic m_step(input bit mb, input bit ib);
    bit tick, me, ie;
    int hh, mm;
    tick = (p == int'(D) - 1);
    me = mb & ~mbq;
    ie = ib & ~ibq;
    mbq = mb;
    ibq = ib;
    hh = t / 3600;
    mm = (t / 60) % 60;
    if (md == 0 && tick) t = (t + 1) % 86400;
    else if (md == 1 && ie && !me) t = ((hh + 1) % 24) * 3600 + t % 3600;
    else if (md == 2 && ie && !me) t = hh * 3600 + ((mm + 1) % 60) * 60 + t % 60;
    ex_tick = tick && (md == 0);
    if (p == int'(D) / 2 - 1 || p == int'(D) - 1) ph = !ph;
    p = (p + 1) % int'(D);
    if (me) begin
      if (md == 2) begin
        t = t - t % 60;
        p = 0;
        ph = 0;
      end
      md = (md + 1) % 3;
    end
  endtask

  task automatic check_all(input string where);
    check({where, ".hour"}, 32'(hour_bcd), 32'(to_bcd(t / 3600)));
    check({where, ".min"},  32'(min_bcd),  32'(to_bcd((t / 60) % 60)));
    check({where, ".sec"},  32'(sec_bcd),  32'(to_bcd(t % 60)));
    check({where, ".mode"}, 32'(mode),     32'(md));
    check({where, ".blink"}, 32'(blink),   32'(ph && md != 0));
    check({where, ".sec_tick"}, 32'(sec_tick), 32'(ex_tick));
  endtask

  task automatic cycle(input bit mb, input bit ib, input string where);
    mode_btn = mb;
    inc_btn  = ib;
    @(posedge clk);
    m_step(mb, ib);
    #1;
    check_all(where);
  endtask

  task automatic press(input bit mb, input bit ib, input string where);
    cycle(mb, ib, where);
    cycle(1'b0, 1'b0, where);
  endtask

  task automatic do_reset();
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_reset();
    #1;
    check_all("rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [7:0] h0, m0;
    m_reset();
    #12;
    check_all("reset");
    #10 rst = 1'b0;

    // 1: first second after reset
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, "t1");
      if (sec_tick) cnt++;
    end
    check("t1.tick_count", 32'(cnt), 32'd1);
    check("t1.sec", 32'(sec_bcd), 32'h01);

    // 2: preload 23:59 via set flow, then roll over midnight
    press(1'b1, 1'b0, "t2");
    for (int i = 0; i < 23; i++) press(1'b0, 1'b1, "t2");
    press(1'b1, 1'b0, "t2");
    for (int i = 0; i < 59; i++) press(1'b0, 1'b1, "t2");
    press(1'b1, 1'b0, "t2");
    check("t2.start", {8'h0, hour_bcd, min_bcd, sec_bcd}, {8'h0, hms(23, 59, 0)});
    for (int i = 0; i < 59 * int'(D) - 1; i++) cycle(1'b0, 1'b0, "t2");
    check("t2.pre", {8'h0, hour_bcd, min_bcd, sec_bcd}, {8'h0, hms(23, 59, 59)});
    for (int i = 0; i < int'(D); i++) cycle(1'b0, 1'b0, "t2");
    check("t2.wrap", {8'h0, hour_bcd, min_bcd, sec_bcd}, {8'h0, hms(0, 0, 0)});

    // 3: 25 hour increments wrap to 01, clock frozen
    do_reset();
    press(1'b1, 1'b0, "t3");
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      press(1'b0, 1'b1, "t3");
      if (sec_tick) cnt++;
    end
    check("t3.hour", 32'(hour_bcd), 32'h01);
    check("t3.sec", 32'(sec_bcd), 32'h00);
    check("t3.no_tick", 32'(cnt), 32'd0);

    // 4: minute wrap without carry, then return to RUN
    press(1'b1, 1'b0, "t4");
    for (int i = 0; i < 59; i++) press(1'b0, 1'b1, "t4");
    check("t4.min59", 32'(min_bcd), 32'h59);
    press(1'b0, 1'b1, "t4");
    check("t4.min", 32'(min_bcd), 32'h00);
    check("t4.hour", 32'(hour_bcd), 32'h01);
    cycle(1'b1, 1'b0, "t4");
    check("t4.mode", 32'(mode), 32'd0);
    check("t4.sec", 32'(sec_bcd), 32'h00);
    cnt = 0;
    do begin
      cycle(1'b0, 1'b0, "t4");
      cnt++;
    end while (!sec_tick && cnt < 30);
    check("t4.first_tick", 32'(cnt), 32'd10);

    // 5: held inc gives one edge; mode+inc together drops inc
    press(1'b1, 1'b0, "t5");
    h0 = hour_bcd;
    for (int i = 0; i < 30; i++) cycle(1'b0, 1'b1, "t5");
    cycle(1'b0, 1'b0, "t5");
    check("t5.hold", 32'(hour_bcd), 32'(to_bcd(((h0[7:4] * 10 + h0[3:0]) + 1) % 24)));
    h0 = hour_bcd;
    m0 = min_bcd;
    press(1'b1, 1'b1, "t5");
    check("t5.mode", 32'(mode), 32'd2);
    check("t5.hour", 32'(hour_bcd), 32'(h0));
    check("t5.min", 32'(min_bcd), 32'(m0));

    // 6: async reset in SET_M at 12:34
    do_reset();
    press(1'b1, 1'b0, "t6");
    for (int i = 0; i < 12; i++) press(1'b0, 1'b1, "t6");
    press(1'b1, 1'b0, "t6");
    for (int i = 0; i < 34; i++) press(1'b0, 1'b1, "t6");
    check("t6.pre", {16'h0, hour_bcd, min_bcd}, {16'h0, 8'h12, 8'h34});
    #2 rst = 1'b1;
    m_reset();
    #1;
    check_all("t6.async");
    @(posedge clk);
    #1;
    check_all("t6.held");
    #2 rst = 1'b0;
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, "t6.after");

    // Random button traffic
    for (int i = 0; i < 3000; i++)
      cycle(bit'($urandom_range(0, 19) == 0), bit'($urandom_range(0, 4) == 0), "rand");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
